// File: rtl/serial_comparator.sv
// -----------------------------------------------------------------------------
// serial_comparator
//
// Bit-serial magnitude comparator for the Mini ALU. On an accepted start it
// captures operands a and b. It then walks them LSB-first, one bit per clock.
// A differing bit at a more significant position overrides the relation
// established by the less significant bits. The final less/equal/greater
// result is registered, and done pulses for one cycle.
//
// Optional feature macro: SIGNED_CMP_EN
//   defined   : adds input sgn. sgn=1 compares the operands as two's complement.
//   undefined : the comparison is always unsigned and no sign logic exists.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   start         compare request; honoured in IDLE and DONE only
//   a, b          WIDTH-bit operands, captured on the accepting edge
//   sgn           (SIGNED_CMP_EN only) signed compare, captured with operands
//   busy          high while operand bits are being walked
//   done          one-cycle pulse when a result has just been registered
//   less_than     a < b for the last completed compare
//   equal         a == b for the last completed compare
//   greater_than  a > b for the last completed compare
// -----------------------------------------------------------------------------
module serial_comparator #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef SIGNED_CMP_EN
   input  logic             sgn,
`endif
   output logic             busy,
   output logic             done,
   output logic             less_than,
   output logic             equal,
   output logic             greater_than
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      REL_EQ = 2'd0,
      REL_LT = 2'd1,
      REL_GT = 2'd2
   } rel_t;

   // Decode the running relation into {less_than, equal, greater_than}.
   function automatic logic [2:0] rel_to_onehot(input rel_t r);
      logic [2:0] oh;
      case (r)
         REL_LT:  oh = 3'b100;
         REL_GT:  oh = 3'b001;
         REL_EQ:  oh = 3'b010;
         default: oh = 3'b010;
      endcase
      return oh;
   endfunction

   state_t           state_r,  state_nxt_s;
   rel_t             rel_r,    rel_nxt_s;
   logic [WIDTH-1:0] sa_r,     sa_nxt_s;
   logic [WIDTH-1:0] sb_r,     sb_nxt_s;
   logic [CW-1:0]    cnt_r,    cnt_nxt_s;
   logic             busy_r,   busy_nxt_s;
   logic             done_r,   done_nxt_s;
   logic [2:0]       res_r,    res_nxt_s;
   logic             bit_lt_s, bit_gt_s, last_bit_s;
`ifdef SIGNED_CMP_EN
   logic             sgn_r,    sgn_nxt_s;
`endif

   assign last_bit_s = (cnt_r == CW'(WIDTH - 1));

   // Per-bit relation of the current LSBs; the sign position flips its sense.
   always_comb begin
`ifdef SIGNED_CMP_EN
      if (sgn_r && last_bit_s) begin
         bit_lt_s = sa_r[0] & ~sb_r[0];
         bit_gt_s = ~sa_r[0] & sb_r[0];
      end else begin
         bit_lt_s = ~sa_r[0] & sb_r[0];
         bit_gt_s = sa_r[0] & ~sb_r[0];
      end
`else
      bit_lt_s = ~sa_r[0] & sb_r[0];
      bit_gt_s = sa_r[0] & ~sb_r[0];
`endif
   end

   // Next-state, datapath and output decode for the compare FSM.
   always_comb begin
      state_nxt_s = state_r;
      rel_nxt_s   = rel_r;
      sa_nxt_s    = sa_r;
      sb_nxt_s    = sb_r;
      cnt_nxt_s   = cnt_r;
      done_nxt_s  = 1'b0;
      res_nxt_s   = res_r;
`ifdef SIGNED_CMP_EN
      sgn_nxt_s   = sgn_r;
`endif
      case (state_r)
         // DONE accepts start exactly like IDLE, giving back-to-back compares.
         ST_IDLE, ST_DONE: begin
            if (start) begin
               sa_nxt_s    = a;
               sb_nxt_s    = b;
               cnt_nxt_s   = {CW{1'b0}};
               rel_nxt_s   = REL_EQ;
`ifdef SIGNED_CMP_EN
               sgn_nxt_s   = sgn;
`endif
               state_nxt_s = ST_SHIFT;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            // A differing bit at a higher position replaces the lower verdict.
            if (bit_lt_s) begin
               rel_nxt_s = REL_LT;
            end else if (bit_gt_s) begin
               rel_nxt_s = REL_GT;
            end else begin
               rel_nxt_s = rel_r;
            end
            sa_nxt_s  = {1'b0, sa_r[WIDTH-1:1]};
            sb_nxt_s  = {1'b0, sb_r[WIDTH-1:1]};
            cnt_nxt_s = cnt_r + CW'(1);
            if (last_bit_s) begin
               res_nxt_s   = rel_to_onehot(rel_nxt_s);
               done_nxt_s  = 1'b1;
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_SHIFT;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
      busy_nxt_s = (state_nxt_s == ST_SHIFT);
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         rel_r   <= REL_EQ;
         sa_r    <= {WIDTH{1'b0}};
         sb_r    <= {WIDTH{1'b0}};
         cnt_r   <= {CW{1'b0}};
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         res_r   <= 3'b000;
`ifdef SIGNED_CMP_EN
         sgn_r   <= 1'b0;
`endif
      end else begin
         state_r <= state_nxt_s;
         rel_r   <= rel_nxt_s;
         sa_r    <= sa_nxt_s;
         sb_r    <= sb_nxt_s;
         cnt_r   <= cnt_nxt_s;
         busy_r  <= busy_nxt_s;
         done_r  <= done_nxt_s;
         res_r   <= res_nxt_s;
`ifdef SIGNED_CMP_EN
         sgn_r   <= sgn_nxt_s;
`endif
      end
   end

   assign busy         = busy_r;
   assign done         = done_r;
   assign less_than    = res_r[2];
   assign equal        = res_r[1];
   assign greater_than = res_r[0];

endmodule
